// File: rtl/logic_seq.sv
// Multi-cycle sequencer around the ToyRISC logic unit: iterates 1-bit shifts N times, passes other functions through once.
// Optional LOGIC_SEQ_FLAGS_EN registers zero/neg flags alongside result.
module logic_seq #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       func,
  input  logic [WIDTH-1:0] leftIn,
  input  logic [WIDTH-1:0] rightIn,
  input  logic [CNTW-1:0]  count,
  output logic [WIDTH-1:0] luLeft,
  output logic [WIDTH-1:0] luRight,
  output logic [2:0]       luFunc,
  input  logic [WIDTH-1:0] luOut,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             neg
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_work, r_rgt, r_result;
  logic [2:0]       r_fn;
  logic [CNTW-1:0]  r_remain;

  logic             w_accept, w_is_shift, w_last, w_load_res;
  logic [WIDTH-1:0] w_res_nxt;

  assign w_accept   = start && (r_state != RUN);
  assign w_is_shift = (func[2:1] == 2'b00);
  assign w_last     = (r_state == RUN) && (r_remain == CNTW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_res  = 1'b0;
    w_res_nxt   = luOut;
    case (r_state)
      IDLE, DONE: begin
        if (w_accept) begin
          // A zero-count shift completes straight away with the operand untouched
          if (w_is_shift && (count == '0)) begin
            w_state_nxt = DONE;
            w_load_res  = 1'b1;
            w_res_nxt   = leftIn;
          end else begin
            w_state_nxt = RUN;
          end
        end else if (r_state == DONE) begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        if (w_last) begin
          w_state_nxt = DONE;
          w_load_res  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work   <= '0;
      r_rgt    <= '0;
      r_fn     <= 3'b000;
      r_remain <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_work   <= leftIn;
        r_rgt    <= rightIn;
        r_fn     <= func;
        r_remain <= w_is_shift ? count : CNTW'(1);
      end else if (r_state == RUN) begin
        r_work   <= luOut;
        r_remain <= r_remain - CNTW'(1);
      end
      if (w_load_res) r_result <= w_res_nxt;
    end
  end

`ifdef LOGIC_SEQ_FLAGS_EN
  logic r_zero, r_neg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero <= 1'b0;
      r_neg  <= 1'b0;
    end else if (w_load_res) begin
      r_zero <= (w_res_nxt == '0);
      r_neg  <= w_res_nxt[WIDTH-1];
    end
  end
  assign zero = r_zero;
  assign neg  = r_neg;
`else
  assign zero = 1'b0;
  assign neg  = 1'b0;
`endif

  assign luLeft  = r_work;
  assign luRight = r_rgt;
  assign luFunc  = r_fn;
  assign busy    = (r_state == RUN);
  assign done    = (r_state == DONE);
  assign result  = r_result;

endmodule

// File: tb/tb_logic_seq.sv
// Directed bench for logic_seq with a behavioural logic-unit model on the luOut return path.
module tb_logic_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  func;
  logic [31:0] leftIn, rightIn;
  logic [4:0]  count;
  logic [31:0] luLeft, luRight, luOut, result;
  logic [2:0]  luFunc;
  logic        busy, done, zero, neg;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  logic_seq #(.WIDTH(32), .CNTW(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .func(func),
    .leftIn(leftIn), .rightIn(rightIn), .count(count),
    .luLeft(luLeft), .luRight(luRight), .luFunc(luFunc), .luOut(luOut),
    .busy(busy), .done(done), .result(result), .zero(zero), .neg(neg)
  );

  // Single-cycle logic unit: lsh/ash shift right by one bit
  always_comb begin
    case (luFunc)
      3'b000:  luOut = luLeft >> 1;
      3'b001:  luOut = {luLeft[31], luLeft[31:1]};
      3'b010:  luOut = luLeft;
      3'b011:  luOut = {luLeft[15:0], luLeft[31:16]};
      3'b100:  luOut = ~luLeft;
      3'b101:  luOut = luLeft & luRight;
      3'b110:  luOut = luLeft | luRight;
      default: luOut = luLeft ^ luRight;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_flags(input string name, input logic [31:0] exp_res);
    logic ez, en;
`ifdef LOGIC_SEQ_FLAGS_EN
    ez = (exp_res == 32'h0);
    en = exp_res[31];
`else
    ez = 1'b0;
    en = 1'b0;
`endif
    chk({name, ".zero"}, {31'h0, zero}, {31'h0, ez});
    chk({name, ".neg"},  {31'h0, neg},  {31'h0, en});
  endtask

  // Called at a negedge; accepts on the next posedge and returns at the negedge inside the DONE cycle.
  task automatic run_op(input logic [2:0] f, input logic [31:0] l, input logic [31:0] r,
                        input logic [4:0] c, output int lat, output int bsy);
    bit seen;
    start = 1'b1; func = f; leftIn = l; rightIn = r; count = c;
    @(posedge clk);
    #1;
    start = 1'b0; leftIn = 32'h5555AAAA; rightIn = 32'h0; count = 5'd31; func = 3'b111;
    lat = 0; bsy = 0; seen = 0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      if (busy) bsy++;
      if (busy && done) begin
        failures++;
        $display("FAIL busy_and_done: both high at lat %0d", lat);
      end
      if (done) seen = 1;
    end
  endtask

  typedef struct {
    string       name;
    logic [2:0]  f;
    logic [31:0] l, r;
    logic [4:0]  c;
    logic [31:0] exp;
    int          lat, bsy;
  } vec_t;

  vec_t vecs[9];
  int lat, bsy, dcnt;

  initial begin
    vecs[0] = '{"lsh4",   3'b000, 32'h80000000, 32'h0,        5'd4,  32'h08000000, 5,  4};
    vecs[1] = '{"ash31",  3'b001, 32'h80000000, 32'h0,        5'd31, 32'hFFFFFFFF, 32, 31};
    vecs[2] = '{"ash31p", 3'b001, 32'h40000000, 32'h0,        5'd31, 32'h00000000, 32, 31};
    vecs[3] = '{"swap",   3'b011, 32'h12345678, 32'h0,        5'd7,  32'h56781234, 2,  1};
    vecs[4] = '{"xor",    3'b111, 32'hFFFF0000, 32'h0F0F0F0F, 5'd19, 32'hF0F00F0F, 2,  1};
    vecs[5] = '{"and",    3'b101, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000, 2,  1};
    vecs[6] = '{"or",     3'b110, 32'h00FF0000, 32'h0000000F, 5'd3,  32'h00FF000F, 2,  1};
    vecs[7] = '{"lsh12",  3'b000, 32'h0000F000, 32'h0,        5'd12, 32'h0000000F, 13, 12};
    vecs[8] = '{"ash1",   3'b001, 32'hC0000001, 32'h0,        5'd1,  32'hE0000000, 2,  1};

    rst_n = 1'b0; start = 1'b0; func = 3'b0; leftIn = '0; rightIn = '0; count = '0;
    @(negedge clk);
    chk("rst.busy",   {31'h0, busy}, 32'h0);
    chk("rst.done",   {31'h0, done}, 32'h0);
    chk("rst.result", result, 32'h0);
    chk("rst.zero",   {31'h0, zero}, 32'h0);
    chk("rst.neg",    {31'h0, neg},  32'h0);
    chk("rst.luLeft", luLeft, 32'h0);
    chk("rst.luRight", luRight, 32'h0);
    chk("rst.luFunc", {29'h0, luFunc}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_op(vecs[i].f, vecs[i].l, vecs[i].r, vecs[i].c, lat, bsy);
      chk({vecs[i].name, ".result"}, result, vecs[i].exp);
      chk({vecs[i].name, ".lat"}, lat, vecs[i].lat);
      chk({vecs[i].name, ".busy_cycles"}, bsy, vecs[i].bsy);
      chk_flags(vecs[i].name, vecs[i].exp);
      @(negedge clk);
      chk({vecs[i].name, ".done_pulse"}, {31'h0, done}, 32'h0);
      chk({vecs[i].name, ".hold"}, result, vecs[i].exp);
    end

    // zero-count shift then back-to-back neg accepted in the DONE cycle
    run_op(3'b000, 32'hDEADBEEF, 32'h0, 5'd0, lat, bsy);
    chk("lsh0.result", result, 32'hDEADBEEF);
    chk("lsh0.lat", lat, 1);
    chk("lsh0.busy_cycles", bsy, 0);
    run_op(3'b100, 32'h00000000, 32'h0, 5'd9, lat, bsy);
    chk("b2b_neg.result", result, 32'hFFFFFFFF);
    chk("b2b_neg.lat", lat, 2);
    chk_flags("b2b_neg", 32'hFFFFFFFF);
    @(negedge clk);

    // start during RUN is ignored
    start = 1'b1; func = 3'b000; leftIn = 32'hABCD1234; rightIn = 32'h0; count = 5'd10;
    @(posedge clk); #1;
    start = 1'b0;
    dcnt = 0; lat = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 3) begin
        start = 1'b1; func = 3'b100; leftIn = 32'h11111111; count = 5'd2;
      end else begin
        start = 1'b0;
      end
      if (done) begin dcnt++; lat = k; end
    end
    chk("ignore.done_count", dcnt, 1);
    chk("ignore.lat", lat, 11);
    chk("ignore.result", result, 32'h002AF344);

    // reset mid-RUN aborts
    @(negedge clk);
    start = 1'b1; func = 3'b001; leftIn = 32'h80000000; count = 5'd20;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort.busy_before", {31'h0, busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("abort.busy", {31'h0, busy}, 32'h0);
    chk("abort.done", {31'h0, done}, 32'h0);
    chk("abort.result", result, 32'h0);
    chk("abort.luLeft", luLeft, 32'h0);
    chk("abort.zero", {31'h0, zero}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    chk("abort.no_activity", dcnt, 0);
    run_op(3'b010, 32'hA5A5A5A5, 32'hA5A5A5A5, 5'd17, lat, bsy);
    chk("move.result", result, 32'hA5A5A5A5);
    chk("move.lat", lat, 2);
    chk("move.busy_cycles", bsy, 1);
    chk_flags("move", 32'hA5A5A5A5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/logic_seq.md
# logic_seq

Multi-cycle sequencer wrapped around the single-cycle logic unit in the ToyRISC execute stage. It latches an operation and its operands, drives the logic unit's `leftOp`/`rightOp`/`func` inputs, and feeds `logicOut` back as the next left operand. This turns the unit's 1-bit `lsh`/`ash` into N-bit shifts (N = 0..31). Non-shift functions (move, swap, neg, and, or, xor) pass through in one iteration, so every logic instruction sees the same start/done handshake.

## Interface
- `WIDTH`, 32: datapath width. Must match the logic unit.
- `CNTW`, 5: shift-count width. Maximum count is 2^CNTW−1.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request. Sampled only when the FSM is in IDLE or DONE.
- `func` in 3: logic-unit function code. 000 lsh, 001 ash, 010 move, 011 swap, 100 neg, 101 and, 110 or, 111 xor.
- `leftIn` in WIDTH: left operand.
- `rightIn` in WIDTH: right operand.
- `count` in CNTW: shift amount. Ignored for func ≥ 010.
- `luLeft` out WIDTH: drives logic unit `leftOp`.
- `luRight` out WIDTH: drives logic unit `rightOp`.
- `luFunc` out 3: drives logic unit `func`.
- `luOut` in WIDTH: logic unit `logicOut`. Combinational return path.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse in DONE.
- `result` out WIDTH: last completed result. Held until the next completion.
- `zero` out 1: result == 0 (see Configuration).
- `neg` out 1: result[WIDTH−1] (see Configuration).

## Operation
- State registers: `work` (WIDTH), `rgt` (WIDTH), `fn` (3), `remain` (CNTW).
- States are IDLE, RUN and DONE. Encoding is free.
- IDLE or DONE with start=1 captures `work`←leftIn, `rgt`←rightIn, `fn`←func, then branches:
  - Shift (func 000/001) with count≠0: `remain`←count, go to RUN.
  - Shift with count=0: go to DONE. Result is leftIn unchanged.
  - Non-shift: `remain`←1, go to RUN.
- IDLE with start=0: stay in IDLE.
- DONE with start=0: go to IDLE.
- RUN, each cycle:
  - `work`←luOut and `remain`←remain−1.
  - If `remain`==1 this cycle, go to DONE. Otherwise stay in RUN.
- On entry to DONE, `result`←final `work` value. `done` is high for exactly one cycle.
- `luLeft`=`work`, `luRight`=`rgt` and `luFunc`=`fn` in all states. Only RUN-state values are consumed.
- start while in RUN is ignored and not queued.
- Inputs are sampled only on the accepting edge. Later changes have no effect on the operation in flight.
- Shift-by-N is exact iteration: lsh zero-fills, ash sign-fills. There is no modular wrap of count.

## Timing
- Reset (asynchronous assert, takes effect immediately):
  - State IDLE.
  - busy=0, done=0, result=0, zero=0, neg=0.
  - `work`, `rgt`, `fn` and `remain` all 0, so luLeft=0, luRight=0, luFunc=000.
- Reset deassertion is synchronised externally. The first active edge after it may accept start.
- Latency is counted from the accepting edge E to the cycle in which done=1:
  - Shift with count N≥1: done in cycle E+N+1, busy high for N cycles.
  - Non-shift: done in cycle E+2, busy high for 1 cycle.
  - Shift with count 0: done in cycle E+1, busy never high.
- Back-to-back: start=1 during the DONE cycle is accepted on that edge. One issue per N+1 cycles, no bubble.
- Reset mid-RUN aborts the operation. `result` is cleared and no done pulse is produced.
- busy and done are never high in the same cycle.

## Configuration
- `LOGIC_SEQ_FLAGS_EN` defined:
  - `zero` and `neg` are registered alongside `result` on entry to DONE.
  - Both hold with `result` and are cleared by reset.
- `LOGIC_SEQ_FLAGS_EN` undefined:
  - `zero` and `neg` are tied to 0.
  - No flag registers are synthesised.
  - All other behaviour is identical.

## Test plan
- lsh: leftIn=0x80000000, count=4 → done 5 cycles after accept, result=0x08000000, busy high 4 cycles. With flags: zero=0, neg=0.
- ash: leftIn=0x80000000, count=31 → done at E+32, result=0xFFFFFFFF. With flags: neg=1. Then ash of 0x40000000 by 31 → result=0x00000000, zero=1 (flags build).
- Non-shift, each run separately:
  - swap 0x12345678 → 0x56781234.
  - xor 0xFFFF0000 ^ 0x0F0F0F0F → 0xF0F00F0F.
  - Each done at E+2. count input changes must have no effect.
- lsh with count=0 on 0xDEADBEEF → done at E+1, result=0xDEADBEEF, busy never asserted. Then assert start in the DONE cycle with neg 0x0 → accepted, result=0xFFFFFFFF two cycles later.
- Issue lsh count=10, then pulse start with different operands at RUN cycle 3 → ignored. Single done, result = original operand >> 10.
- Issue ash count=20 on 0x80000000, assert rst_n=0 mid-RUN → immediately busy=0, done=0, result=0. No done pulse after release. A fresh move of 0xA5A5A5A5 completes normally.
